// File: rtl/joy_pad_responder_if.sv
// rtl/joy_pad_responder_if.sv - host/pad serial bus: clock, command, select, data, /ACK
interface joy_pad_responder_if;
    logic joy_clk;
    logic joy_cmd;
    logic joy_att;
    logic joy_data;
    logic joy_ack;

    modport master (
        output joy_clk,
        output joy_cmd,
        output joy_att,
        input  joy_data,
        input  joy_ack
    );

    modport slave (
        input  joy_clk,
        input  joy_cmd,
        input  joy_att,
        output joy_data,
        output joy_ack
    );
endinterface

// File: rtl/joy_pad_responder.sv
// rtl/joy_pad_responder.sv - game pad poll responder; JOY_PAD_ANALOG_EN adds ID 0x73 and four stick bytes
module joy_pad_responder #(
    parameter int ACK_DELAY = 16,
    parameter int ACK_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    joy_pad_responder_if.slave   joy,
    input  logic [15:0]          buttons,
    input  logic [31:0]          stick,
    output logic [7:0]           rx_byte,
    output logic                 rx_valid,
    output logic                 poll_done
);

`ifdef JOY_PAD_ANALOG_EN
    localparam logic [7:0] PAD_ID   = 8'h73;
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [7:0] PAD_ID   = 8'h41;
    localparam logic [3:0] LAST_IDX = 4'd4;
`endif

    localparam logic [7:0] DELAY_M1 = 8'(ACK_DELAY - 1);
    localparam logic [7:0] WIDTH_M1 = 8'(ACK_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, RX_BYTE, ACK_WAIT, ACK_PULSE, DONE, IGNORE
    } state_t;

    state_t      state;
    logic [1:0]  clk_sync, cmd_sync, att_sync;
    logic        clk_prev;
    logic [1:0]  sync_fill;
    logic        armed;
    logic [2:0]  bit_cnt;
    logic [3:0]  byte_idx;
    logic [7:0]  delay_cnt;
    logic [7:0]  tx_shift, rx_shift;
    logic [15:0] btn_snap;
    logic [31:0] stick_snap;
    logic        data_q, ack_q;

    logic clk_s, cmd_s, att_s, rise, fall;
    logic [7:0] rx_next;

    assign clk_s   = clk_sync[1];
    assign cmd_s   = cmd_sync[1];
    assign att_s   = att_sync[1];
    assign rise    = clk_s & ~clk_prev;
    assign fall    = ~clk_s & clk_prev;
    assign rx_next = {cmd_s, rx_shift[6:0]};

    assign joy.joy_data = data_q;
    assign joy.joy_ack  = ack_q;

    function automatic logic [7:0] resp_byte(input logic [3:0] idx,
                                             input logic [15:0] btn,
                                             input logic [31:0] stk);
        case (idx)
            4'd0:    return 8'hFF;
            4'd1:    return PAD_ID;
            4'd2:    return 8'h5A;
            4'd3:    return ~btn[7:0];
            4'd4:    return ~btn[15:8];
            4'd5:    return stk[7:0];
            4'd6:    return stk[15:8];
            4'd7:    return stk[23:16];
            4'd8:    return stk[31:24];
            default: return 8'hFF;
        endcase
    endfunction

    // armed only rises once a genuine high select has passed through the
    // synchronizer, so a select held low across reset is not answered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            cmd_sync  <= 2'b11;
            att_sync  <= 2'b11;
            clk_prev  <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], joy.joy_clk};
            cmd_sync  <= {cmd_sync[0], joy.joy_cmd};
            att_sync  <= {att_sync[0], joy.joy_att};
            clk_prev  <= clk_s;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & att_s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_q     <= 1'b1;
            ack_q      <= 1'b1;
            rx_byte    <= 8'h00;
            rx_valid   <= 1'b0;
            poll_done  <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_idx   <= 4'd0;
            delay_cnt  <= 8'd0;
            tx_shift   <= 8'h00;
            rx_shift   <= 8'h00;
            btn_snap   <= 16'h0000;
            stick_snap <= 32'h0000_0000;
        end else begin
            rx_valid  <= 1'b0;
            poll_done <= 1'b0;
            if (att_s) begin
                // deselect wins over everything, including a same-cycle edge
                state    <= IDLE;
                data_q   <= 1'b1;
                ack_q    <= 1'b1;
                bit_cnt  <= 3'd0;
                byte_idx <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        data_q <= 1'b1;
                        ack_q  <= 1'b1;
                        if (armed) begin
                            state    <= RX_BYTE;
                            byte_idx <= 4'd0;
                            bit_cnt  <= 3'd0;
                            tx_shift <= 8'hFF;
                        end
                    end
                    RX_BYTE: begin
                        if (fall) begin
                            data_q <= tx_shift[bit_cnt];
                        end else if (rise) begin
                            rx_shift[bit_cnt] <= cmd_s;
                            bit_cnt           <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_byte  <= rx_next;
                                rx_valid <= 1'b1;
                                byte_idx <= byte_idx + 4'd1;
                                if (byte_idx == 4'd1) begin
                                    btn_snap   <= buttons;
                                    stick_snap <= stick;
                                end
                                if ((byte_idx == 4'd0 && rx_next != 8'h01) ||
                                    (byte_idx == 4'd1 && rx_next != 8'h42)) begin
                                    state  <= IGNORE;
                                    data_q <= 1'b1;
                                end else if (byte_idx == LAST_IDX) begin
                                    state     <= DONE;
                                    data_q    <= 1'b1;
                                    poll_done <= 1'b1;
                                end else begin
                                    state     <= ACK_WAIT;
                                    delay_cnt <= DELAY_M1;
                                end
                            end
                        end
                    end
                    ACK_WAIT: begin
                        if (delay_cnt == 8'd0) begin
                            state     <= ACK_PULSE;
                            ack_q     <= 1'b0;
                            delay_cnt <= WIDTH_M1;
                        end else begin
                            delay_cnt <= delay_cnt - 8'd1;
                        end
                    end
                    ACK_PULSE: begin
                        if (delay_cnt == 8'd0) begin
                            state    <= RX_BYTE;
                            ack_q    <= 1'b1;
                            bit_cnt  <= 3'd0;
                            tx_shift <= resp_byte(byte_idx, btn_snap, stick_snap);
                        end else begin
                            delay_cnt <= delay_cnt - 8'd1;
                        end
                    end
                    DONE, IGNORE: begin
                        data_q <= 1'b1;
                        ack_q  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_joy_pad_responder.sv
// tb/tb_joy_pad_responder.sv - randomized host polls checked against a byte-table model of the pad
module tb_joy_pad_responder;
    localparam int ACK_DELAY = 16;
    localparam int ACK_WIDTH = 8;
    localparam int HALF      = 6;
`ifdef JOY_PAD_ANALOG_EN
    localparam int         N_BYTES = 9;
    localparam logic [7:0] EXP_ID  = 8'h73;
`else
    localparam int         N_BYTES = 5;
    localparam logic [7:0] EXP_ID  = 8'h41;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] buttons;
    logic [31:0] stick;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        poll_done;

    joy_pad_responder_if jif();

    joy_pad_responder #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .joy       (jif),
        .buttons   (buttons),
        .stick     (stick),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .poll_done (poll_done)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         rv_cnt = 0;
    int         pd_cnt = 0;
    logic [7:0] last_rx = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt  <= rv_cnt + 1;
            last_rx <= rx_byte;
        end
        if (poll_done) pd_cnt <= pd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // What a pad must put on the wire for each byte position of a poll.
    function automatic logic [7:0] exp_byte(input int idx, input logic [15:0] btn, input logic [31:0] stk);
        logic [7:0] seq [9];
        seq = '{8'hFF, EXP_ID, 8'h5A, ~btn[7:0], ~btn[15:8],
                stk[7:0], stk[15:8], stk[23:16], stk[31:24]};
        return seq[idx];
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_byte(input logic [7:0] cmd, input int nbits, output logic [7:0] got);
        got = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            jif.joy_clk = 1'b0;
            jif.joy_cmd = cmd[i];
            wait_clks(HALF);
            got[i] = jif.joy_data;
            jif.joy_clk = 1'b1;
            wait_clks(HALF);
        end
    endtask

    task automatic wait_ack(output bit seen, output int width);
        seen  = 1'b0;
        width = 0;
        for (int t = 0; t < ACK_DELAY + 40 && !seen; t++) begin
            if (jif.joy_ack === 1'b0) seen = 1'b1;
            else wait_clks(1);
        end
        while (seen && jif.joy_ack === 1'b0 && width < 1000) begin
            width++;
            wait_clks(1);
        end
    endtask

    task automatic count_ack_lows(input int cycles, output int lows);
        lows = 0;
        for (int t = 0; t < cycles; t++) begin
            if (jif.joy_ack !== 1'b1) lows++;
            wait_clks(1);
        end
    endtask

    task automatic run_poll(input logic [15:0] btn, input logic [15:0] btn2,
                            input logic [31:0] stk, input string tag);
        int rv0, pd0, w, lows;
        bit seen;
        logic [7:0] cmd, got;
        buttons = btn;
        stick   = stk;
        jif.joy_att = 1'b0;
        wait_clks(6);
        rv0 = rv_cnt;
        pd0 = pd_cnt;
        for (int b = 0; b < N_BYTES; b++) begin
            cmd = (b == 0) ? 8'h01 : (b == 1) ? 8'h42 : 8'($urandom);
            if (b == 3) begin
                buttons = btn2;
                stick   = ~stk;
            end
            xfer_byte(cmd, 8, got);
            check($sformatf("%s byte%0d", tag, b), got, exp_byte(b, btn, stk));
            check($sformatf("%s rx_byte%0d", tag, b), last_rx, cmd);
            if (b < N_BYTES - 1) begin
                wait_ack(seen, w);
                check($sformatf("%s ack_seen%0d", tag, b), seen, 1);
                check($sformatf("%s ack_width%0d", tag, b), w, ACK_WIDTH);
            end else begin
                count_ack_lows(40, lows);
                check($sformatf("%s no_final_ack", tag), lows, 0);
            end
        end
        check($sformatf("%s rx_valid_cnt", tag), rv_cnt - rv0, N_BYTES);
        check($sformatf("%s poll_done_cnt", tag), pd_cnt - pd0, 1);
        check($sformatf("%s done_data", tag), jif.joy_data, 1);
        jif.joy_att = 1'b1;
        wait_clks(6);
    endtask

    task automatic bad_poll(input logic [7:0] b0, input logic [7:0] b1, input string tag);
        int rv0, w, lows, n_ok;
        bit seen;
        logic [7:0] got;
        jif.joy_att = 1'b0;
        wait_clks(6);
        rv0  = rv_cnt;
        n_ok = (b0 == 8'h01) ? 2 : 1;
        xfer_byte(b0, 8, got);
        check({tag, " b0_data"}, got, 8'hFF);
        check({tag, " b0_rx"}, last_rx, b0);
        if (b0 == 8'h01) begin
            wait_ack(seen, w);
            check({tag, " b0_ack"}, seen, 1);
            xfer_byte(b1, 8, got);
            check({tag, " b1_data"}, got, EXP_ID);
            check({tag, " b1_rx"}, last_rx, b1);
        end
        count_ack_lows(40, lows);
        check({tag, " no_ack"}, lows, 0);
        for (int i = 0; i < 3; i++) begin
            xfer_byte(8'($urandom), 8, got);
            check($sformatf("%s idle_data%0d", tag, i), got, 8'hFF);
        end
        check({tag, " rx_cnt"}, rv_cnt - rv0, n_ok);
        jif.joy_att = 1'b1;
        wait_clks(6);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] got, x;
        bit seen;
        int w, lows, rv0;

        rst = 1'b1;
        jif.joy_clk = 1'b1;
        jif.joy_cmd = 1'b1;
        jif.joy_att = 1'b1;
        buttons = 16'h0000;
        stick   = 32'h0;
        wait_clks(3);
        check("reset joy_data", jif.joy_data, 1);
        check("reset joy_ack", jif.joy_ack, 1);
        check("reset rx_byte", rx_byte, 8'h00);
        check("reset rx_valid", rx_valid, 0);
        check("reset poll_done", poll_done, 0);
        rst = 1'b0;
        wait_clks(5);

        run_poll(16'h0009, 16'h0009, 32'h80FF0010, "basic");
        run_poll(16'h0001, 16'h8000, 32'($urandom), "snapshot");
        for (int i = 0; i < 5; i++)
            run_poll(16'($urandom), 16'($urandom), 32'($urandom), $sformatf("rand%0d", i));

        bad_poll(8'h81, 8'h00, "bad_first81");
        do x = 8'($urandom); while (x == 8'h01);
        bad_poll(x, 8'h00, "bad_first_rnd");
        do x = 8'($urandom); while (x == 8'h42);
        bad_poll(8'h01, x, "bad_second");

        // deselect partway through byte 2
        jif.joy_att = 1'b0;
        wait_clks(6);
        rv0 = rv_cnt;
        xfer_byte(8'h01, 8, got);
        wait_ack(seen, w);
        xfer_byte(8'h42, 8, got);
        wait_ack(seen, w);
        xfer_byte(8'h00, 4, got);
        jif.joy_att = 1'b1;
        wait_clks(4);
        check("abort joy_data", jif.joy_data, 1);
        check("abort joy_ack", jif.joy_ack, 1);
        check("abort rx_cnt", rv_cnt - rv0, 2);
        wait_clks(4);
        run_poll(16'($urandom), 16'($urandom), 32'($urandom), "after_abort");

        // reset in the middle of an /ACK pulse
        jif.joy_att = 1'b0;
        wait_clks(6);
        xfer_byte(8'h01, 8, got);
        seen = 1'b0;
        for (int t = 0; t < ACK_DELAY + 40 && !seen; t++) begin
            if (jif.joy_ack === 1'b0) seen = 1'b1;
            else wait_clks(1);
        end
        check("rst ack_reached", seen, 1);
        wait_clks(2);
        rst = 1'b1;
        #1;
        check("rst ack_released", jif.joy_ack, 1);
        check("rst data_high", jif.joy_data, 1);
        wait_clks(2);
        check("rst rx_byte", rx_byte, 8'h00);
        rst = 1'b0;
        wait_clks(6);
        rv0 = rv_cnt;
        xfer_byte(8'h01, 8, got);
        check("rst held_sel data", got, 8'hFF);
        count_ack_lows(40, lows);
        check("rst held_sel no_ack", lows, 0);
        check("rst held_sel rx_cnt", rv_cnt - rv0, 0);
        jif.joy_att = 1'b1;
        wait_clks(6);
        run_poll(16'($urandom), 16'($urandom), 32'($urandom), "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
